slc3_mem_responder: RTL

- Memory-side responder for the SLC-3 datapath. The CPU's MAR/MDR path initiates read and write requests; this block completes them.
- Contains a single-port on-chip word RAM, a fixed programmable wait-state sequencer, and memory-mapped I/O at IO_ADDR (switch input, hex display output).
- Returns read data and a one-cycle Ready pulse. The datapath loads Ready/RData into MDR through its MIO_EN path.

---
 rtl/slc3_mem_responder_if.sv | 39 +++
 rtl/slc3_mem_responder.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/slc3_mem_responder_if.sv
// -----------------------------------------------------------------------------
// slc3_mem_responder_if
//   Request/response bus between the SLC-3 MAR/MDR datapath (master) and the
//   memory responder (slave). SW rides on the same bundle because it is
//   sampled by the responder on behalf of the CPU.
//
//   Req     master->slave  request strobe, only looked at while idle
//   WE      master->slave  1 = write, 0 = read
//   Addr    master->slave  16-bit word address (from MAR)
//   WData   master->slave  write data (from MDR)
//   SW      master->slave  raw, asynchronous switch inputs
//   RData   slave->master  registered read data
//   Ready   slave->master  one-cycle completion pulse
//   Busy    slave->master  high while a request is in flight
//   Err     slave->master  one-cycle out-of-range pulse, coincident with Ready
//   Hex_Out slave->master  hex display register
// -----------------------------------------------------------------------------
interface slc3_mem_responder_if;
    logic        Req;
    logic        WE;
    logic [15:0] Addr;
    logic [15:0] WData;
    logic [15:0] SW;
    logic [15:0] RData;
    logic        Ready;
    logic        Busy;
    logic        Err;
    logic [15:0] Hex_Out;

    modport master (
        output Req, WE, Addr, WData, SW,
        input  RData, Ready, Busy, Err, Hex_Out
    );

    modport slave (
        input  Req, WE, Addr, WData, SW,
        output RData, Ready, Busy, Err, Hex_Out
    );
endinterface

// File: rtl/slc3_mem_responder.sv
// -----------------------------------------------------------------------------
// slc3_mem_responder
//   Memory-side responder for the SLC-3 datapath. Accepts one read or write at
//   a time, waits WAIT_STATES cycles, then commits the access and raises Ready
//   for a single cycle. Backing store is a 2^ADDR_BITS x 16 word RAM; the
//   word at IO_ADDR is memory-mapped I/O (reads return synchronized switches,
//   writes load the hex display register). Any other address is out of range:
//   reads return zero, writes are dropped, and Err pulses with Ready.
//
//   Clk    in   system clock, rising edge
//   Reset  in   asynchronous, active-high reset (RAM contents are kept)
//   bus    slave modport of slc3_mem_responder_if (Req/WE/Addr/WData/SW in,
//               RData/Ready/Busy/Err/Hex_Out out)
// -----------------------------------------------------------------------------
module slc3_mem_responder #(
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_STATES = 2,
    parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    slc3_mem_responder_if.slave   bus
);

    localparam int         DEPTH = 1 << ADDR_BITS;
    localparam logic [3:0] WS    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                 r_state, w_next;
    logic [3:0]             r_cnt, w_cnt_next;

    // request captured at the accept edge
    logic                   r_we;
    logic [15:0]            r_addr;
    logic [15:0]            r_wdata;
    logic                   r_oor;

    logic [15:0]            r_sw_meta;
    logic [15:0]            r_sw_sync;
    logic [15:0]            r_rdata;
    logic [15:0]            r_hex;

    logic [15:0]            r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_commit;
    logic                   w_acc_we;
    logic [15:0]            w_acc_addr;
    logic [15:0]            w_acc_wdata;
    logic                   w_is_io;
    logic                   w_is_ram;
    logic [ADDR_BITS-1:0]   w_idx;

    // -------------------------------------------------------------------------
    // Next-state logic. The commit happens on the edge that enters RESP, which
    // is the accept edge itself when there are no wait states.
    // -------------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        w_commit   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.Req) begin
                    w_accept = 1'b1;
                    if (WS == 4'd0) begin
                        w_next   = S_RESP;
                        w_commit = 1'b1;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = WS;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next   = S_RESP;
                    w_commit = 1'b1;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Access source: in IDLE the only possible commit is the zero-wait case,
    // where the request has not been latched yet, so take it from the bus.
    // -------------------------------------------------------------------------
    always_comb begin
        if (r_state == S_IDLE) begin
            w_acc_we    = bus.WE;
            w_acc_addr  = bus.Addr;
            w_acc_wdata = bus.WData;
        end else begin
            w_acc_we    = r_we;
            w_acc_addr  = r_addr;
            w_acc_wdata = r_wdata;
        end
    end

    // I/O wins if IO_ADDR ever falls inside the RAM window
    assign w_is_io  = (w_acc_addr == IO_ADDR);
    assign w_is_ram = !w_is_io && ((w_acc_addr >> ADDR_BITS) == 16'd0);
    assign w_idx    = w_acc_addr[ADDR_BITS-1:0];

    // -------------------------------------------------------------------------
    // Control, request latch, SW synchronizer, read data and hex register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 4'd0;
            r_we      <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 16'h0000;
            r_oor     <= 1'b0;
            r_sw_meta <= 16'h0000;
            r_sw_sync <= 16'h0000;
            r_rdata   <= 16'h0000;
            r_hex     <= 16'h0000;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_next;
            r_sw_meta <= bus.SW;
            r_sw_sync <= r_sw_meta;

            if (w_accept) begin
                r_we    <= bus.WE;
                r_addr  <= bus.Addr;
                r_wdata <= bus.WData;
                // w_acc_* equals the bus in IDLE, so the decode is for this request
                r_oor   <= !(w_is_io || w_is_ram);
            end

            if (w_commit) begin
                if (w_acc_we) begin
                    if (w_is_io)
                        r_hex <= w_acc_wdata;
                end else if (w_is_io) begin
                    r_rdata <= r_sw_sync;
                end else if (w_is_ram) begin
                    r_rdata <= r_mem[w_idx];
                end else begin
                    r_rdata <= 16'h0000;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM write port. Not reset so contents survive Reset; the Reset term keeps
    // a zero-wait request present during reset from writing.
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (w_commit && w_acc_we && w_is_ram && !Reset)
            r_mem[w_idx] <= w_acc_wdata;
    end

    assign bus.Ready   = (r_state == S_RESP);
    assign bus.Busy    = (r_state != S_IDLE);
    assign bus.Err     = (r_state == S_RESP) && r_oor;
    assign bus.RData   = r_rdata;
    assign bus.Hex_Out = r_hex;

endmodule
